// File: rtl/seq_shift_reg.sv
// Multi-mode bit-serial shift register: parallel load, then shift/rotate by a commanded count.
// Optional SEQ_SHIFT_ARITH_EN turns mode 01 into an arithmetic right shift.
module seq_shift_reg #(
  parameter int WIDTH = 7,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  // Handshake: load/start are sampled only when en=1 and busy=0; once a command
  // is accepted busy stays high until the edge that raises done for one cycle.
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               ser_out_q, ser_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [AMT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic               fill_q, fill_d;
  logic               shr_fill;

  always_comb begin
`ifdef SEQ_SHIFT_ARITH_EN
    shr_fill = q_q[WIDTH-1];
`else
    shr_fill = fill_q;
`endif
  end

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    ser_out_d = ser_out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    fill_d    = fill_q;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (load) begin
            q_d = d;
          end else if (start) begin
            if (amount != '0) begin
              mode_d  = mode;
              fill_d  = ser_in;
              cnt_d   = amount;
              busy_d  = 1'b1;
              state_d = SHIFT;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        SHIFT: begin
          case (mode_q)
            2'b00: begin
              q_d       = {q_q[WIDTH-2:0], fill_q};
              ser_out_d = q_q[WIDTH-1];
            end
            2'b01: begin
              q_d       = {shr_fill, q_q[WIDTH-1:1]};
              ser_out_d = q_q[0];
            end
            2'b10: begin
              q_d       = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
              ser_out_d = q_q[WIDTH-1];
            end
            default: begin
              q_d       = {q_q[0], q_q[WIDTH-1:1]};
              ser_out_d = q_q[0];
            end
          endcase
          cnt_d = cnt_q - CNT_ONE;
          // Last step retires the command on the same edge as the final shift.
          if (cnt_q == CNT_ONE) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      q_q       <= '0;
      ser_out_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      mode_q    <= 2'b00;
      fill_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      ser_out_q <= ser_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      fill_q    <= fill_d;
    end
  end

  assign q       = q_q;
  assign ser_out = ser_out_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_shift_reg.sv
// Directed self-checking bench for seq_shift_reg (WIDTH=7, AMT_W=3).
module tb_seq_shift_reg;

  logic       clk = 1'b0;
  logic       reset, en, load, start, ser_in;
  logic [1:0] mode;
  logic [2:0] amount;
  logic [6:0] d;
  logic [6:0] q;
  logic       ser_out, busy, done;
  int         n_pass = 0;
  int         n_total = 0;

  seq_shift_reg #(.WIDTH(7), .AMT_W(3)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .start(start),
    .mode(mode), .amount(amount), .ser_in(ser_in), .d(d),
    .q(q), .ser_out(ser_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [6:0] val);
    load = 1'b1; d = val;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; load = 1'b0; start = 1'b0;
    mode = 2'b00; amount = 3'd0; ser_in = 1'b0; d = 7'h00;
    tick(); tick();
    n_total++; if (q !== 7'h00) $display("FAIL reset_q: got %b want 0000000", q); else n_pass++;
    n_total++; if ({busy, done, ser_out} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, done, ser_out}); else n_pass++;
    reset = 1'b0; en = 1'b1;
    do_load(7'h01);
    n_total++; if (q !== 7'h01 || done !== 1'b0) $display("FAIL load: got q=%b done=%b want 0000001/0", q, done); else n_pass++;
  endtask

  task automatic test_shl();
    logic [6:0] exp_v [3];
    exp_v = '{7'h02, 7'h04, 7'h08};
    start = 1'b1; mode = 2'b00; amount = 3'd3; ser_in = 1'b0;
    tick();
    start = 1'b0;
    n_total++; if (q !== 7'h01 || busy !== 1'b1) $display("FAIL shl_accept: got q=%b busy=%b want 0000001/1", q, busy); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (q !== exp_v[i] || ser_out !== 1'b0 || busy !== (i < 2) || done !== (i == 2))
        $display("FAIL shl_step%0d: got q=%b so=%b busy=%b done=%b want %b/0/%b/%b",
                 i, q, ser_out, busy, done, exp_v[i], (i < 2), (i == 2));
      else n_pass++;
    end
    tick();
    n_total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL shl_after: got done=%b busy=%b want 0/0", done, busy); else n_pass++;
  endtask

  task automatic test_rotr();
    do_load(7'h01);
    start = 1'b1; mode = 2'b11; amount = 3'd2;
    tick();
    start = 1'b0;
    tick();
    n_total++; if (q !== 7'h40 || ser_out !== 1'b1 || done !== 1'b0) $display("FAIL rotr_step0: got q=%b so=%b done=%b want 1000000/1/0", q, ser_out, done); else n_pass++;
    tick();
    n_total++; if (q !== 7'h20 || ser_out !== 1'b0 || done !== 1'b1 || busy !== 1'b0) $display("FAIL rotr_step1: got q=%b so=%b done=%b busy=%b want 0100000/0/1/0", q, ser_out, done, busy); else n_pass++;
    tick();
    n_total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL rotr_after: got done=%b busy=%b want 0/0", done, busy); else n_pass++;
  endtask

  task automatic test_stall();
    do_load(7'h01);
    start = 1'b1; mode = 2'b00; amount = 3'd4; ser_in = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick();
    en = 1'b0; load = 1'b1; d = 7'h7f;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (q !== 7'h04 || busy !== 1'b1 || done !== 1'b0) $display("FAIL stall%0d: got q=%b busy=%b done=%b want 0000100/1/0", i, q, busy, done);
      else n_pass++;
    end
    en = 1'b1;
    tick();
    n_total++; if (q !== 7'h08 || busy !== 1'b1) $display("FAIL stall_resume: got q=%b busy=%b want 0001000/1", q, busy); else n_pass++;
    tick();
    load = 1'b0;
    n_total++; if (q !== 7'h10 || done !== 1'b1 || busy !== 1'b0) $display("FAIL stall_final: got q=%b done=%b busy=%b want 0010000/1/0", q, done, busy); else n_pass++;
  endtask

  task automatic test_zero_and_priority();
    start = 1'b1; amount = 3'd0;
    tick();
    start = 1'b0;
    n_total++; if (done !== 1'b1 || busy !== 1'b0 || q !== 7'h10) $display("FAIL zero_amt: got done=%b busy=%b q=%b want 1/0/0010000", done, busy, q); else n_pass++;
    tick();
    n_total++; if (done !== 1'b0) $display("FAIL zero_amt_pulse: got done=%b want 0", done); else n_pass++;
    load = 1'b1; start = 1'b1; d = 7'h55; amount = 3'd2;
    tick();
    load = 1'b0; start = 1'b0;
    n_total++; if (q !== 7'h55 || busy !== 1'b0 || done !== 1'b0) $display("FAIL priority: got q=%b busy=%b done=%b want 1010101/0/0", q, busy, done); else n_pass++;
    tick();
    n_total++; if (q !== 7'h55 || busy !== 1'b0) $display("FAIL priority_hold: got q=%b busy=%b want 1010101/0", q, busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    start = 1'b1; mode = 2'b00; amount = 3'd1; ser_in = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_total++; if (q !== 7'h2b || ser_out !== 1'b1 || done !== 1'b1) $display("FAIL b2b_first: got q=%b so=%b done=%b want 0101011/1/1", q, ser_out, done); else n_pass++;
    start = 1'b1; mode = 2'b11; amount = 3'd1;
    tick();
    start = 1'b0;
    n_total++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_accept: got busy=%b done=%b want 1/0", busy, done); else n_pass++;
    tick();
    n_total++; if (q !== 7'h55 || ser_out !== 1'b1 || done !== 1'b1) $display("FAIL b2b_second: got q=%b so=%b done=%b want 1010101/1/1", q, ser_out, done); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_load(7'h7f);
    start = 1'b1; mode = 2'b00; amount = 3'd5; ser_in = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_total++; if (q !== 7'h00 || {busy, done, ser_out} !== 3'b000) $display("FAIL reset_mid: got q=%b flags=%b want 0000000/000", q, {busy, done, ser_out}); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if (done !== 1'b0 || busy !== 1'b0) $display("FAIL reset_mid_quiet%0d: got done=%b busy=%b want 0/0", i, done, busy);
      else n_pass++;
    end
  endtask

  task automatic run_cmd(input logic [1:0] m, input logic [2:0] a, input logic s);
    start = 1'b1; mode = m; amount = a; ser_in = s;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12 && done !== 1'b1; i++) tick();
  endtask

  task automatic test_saturate();
    do_load(7'h00);
    run_cmd(2'b00, 3'd7, 1'b1);
    n_total++; if (done !== 1'b1 || q !== 7'h7f) $display("FAIL shl_sat: got done=%b q=%b want 1/1111111", done, q); else n_pass++;
    do_load(7'h03);
    run_cmd(2'b10, 3'd7, 1'b0);
    n_total++; if (done !== 1'b1 || q !== 7'h03) $display("FAIL rotl_wrap: got done=%b q=%b want 1/0000011", done, q); else n_pass++;
  endtask

  task automatic test_shr();
    logic [6:0] exp_v;
`ifdef SEQ_SHIFT_ARITH_EN
    exp_v = 7'h78;
`else
    exp_v = 7'h08;
`endif
    do_load(7'h40);
    run_cmd(2'b01, 3'd3, 1'b0);
    n_total++; if (done !== 1'b1 || q !== exp_v || ser_out !== 1'b0) $display("FAIL shr: got done=%b q=%b so=%b want 1/%b/0", done, q, ser_out, exp_v); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_shl();
    test_rotr();
    test_stall();
    test_zero_and_priority();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    test_shr();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
